// File: rtl/pcileech_tx_serializer.sv
// Ping-pong 256-bit to 32-bit DW serializer feeding the FT601 TX path.
// Optional filler-DW dropping is enabled with `define PCILEECH_TX_FILLER_DROP_EN.
module pcileech_tx_serializer #(
    parameter logic [31:0] FILLER_DW = 32'h66665555,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [255:0]     din,
    input  logic             din_valid,
    output logic             din_rd_en,
    output logic [31:0]      dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             dout_last,
    output logic [CNT_W-1:0] tx_dw_count
);

    logic [1:0][255:0] slot_q;
    logic [1:0]        full_q, full_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q, dout_last_d;

    logic              xfer;
    logic              skip;
    logic              advance;
    logic [255:0]      rd_word_d;
    logic [31:0]       dw_d;

    always_comb begin
        din_rd_en = ~rst & din_valid & ~full_q[wr_sel_q];
        xfer      = dout_valid_q & dout_ready;
`ifdef PCILEECH_TX_FILLER_DROP_EN
        // A held slot with no valid output means the current DW is filler.
        skip      = full_q[rd_sel_q] & ~dout_valid_q;
`else
        skip      = 1'b0;
`endif
        advance   = xfer | skip;

        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, xfer};

        if (din_rd_en) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end

        if (advance) begin
            if (idx_q == 3'd7) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
                idx_d            = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end

        // Present next cycle's DW directly from din when it lands in the read slot.
        rd_word_d = (din_rd_en && (wr_sel_q == rd_sel_d)) ? din : slot_q[rd_sel_d];
        dw_d      = rd_word_d[{idx_d, 5'd0} +: 32];

`ifdef PCILEECH_TX_FILLER_DROP_EN
        dout_valid_d = full_d[rd_sel_d] & (dw_d != FILLER_DW);
`else
        dout_valid_d = full_d[rd_sel_d];
`endif
        dout_d      = dout_valid_d ? dw_d : dout_q;
        dout_last_d = dout_valid_d & (idx_d == 3'd7);
    end

`ifndef PCILEECH_TX_FILLER_DROP_EN
    logic unused_filler;
    assign unused_filler = ^FILLER_DW;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            full_q       <= 2'b00;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            dout_q       <= 32'd0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (din_rd_en && (wr_sel_q == 1'(i)))
                    slot_q[i] <= din;
            end
            full_q       <= full_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign dout_last   = dout_last_q;
    assign tx_dw_count = cnt_q;

endmodule

// File: tb/tb_pcileech_tx_serializer.sv
// Bench for pcileech_tx_serializer: directed scenarios plus random traffic against a
// queue-based model of held words and read position.
module tb_pcileech_tx_serializer;

    localparam logic [31:0] FILLER = 32'h66665555;
`ifdef PCILEECH_TX_FILLER_DROP_EN
    localparam bit FDROP = 1'b1;
`else
    localparam bit FDROP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_rd_en;
    logic [31:0]  dout;
    logic         dout_valid;
    logic         dout_ready = 1'b1;
    logic         dout_last;
    logic [31:0]  tx_dw_count;

    pcileech_tx_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_rd_en   (din_rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .tx_dw_count (tx_dw_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: words accepted but not yet fully drained, head read position, DW count.
    logic [255:0] mq[$];
    logic [255:0] src[$];
    int           pos = 0;
    logic [31:0]  mcnt = 0;
    int           rd_pulses = 0;
    int           last_seen = 0;
    bit           gate = 1'b1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive_din();
        din       = (src.size() > 0) ? src[0] : '0;
        din_valid = (src.size() > 0) && gate;
    endtask

    task automatic step();
        logic [255:0] w;
        logic [31:0]  exp_dw;
        bit           exp_valid, exp_last, exp_rd, skip, xfer;
        @(negedge clk);
        exp_dw = '0; exp_valid = 0; exp_last = 0; skip = 0;
        if (mq.size() > 0) begin
            w         = mq[0];
            exp_dw    = w[pos*32 +: 32];
            exp_valid = !(FDROP && exp_dw == FILLER);
            skip      = !exp_valid;
            exp_last  = exp_valid && pos == 7;
        end
        exp_rd = din_valid && mq.size() < 2;
        check("dout_valid", {31'd0, dout_valid}, {31'd0, exp_valid});
        check("dout_last", {31'd0, dout_last}, {31'd0, exp_last});
        check("din_rd_en", {31'd0, din_rd_en}, {31'd0, exp_rd});
        check("tx_dw_count", tx_dw_count, mcnt);
        if (exp_valid) check("dout", dout, exp_dw);
        if (dout_last) last_seen++;
        xfer = exp_valid && dout_ready;
        if (exp_rd) begin
            $display("load word %h", din);
            mq.push_back(din);
            void'(src.pop_front());
            rd_pulses++;
        end
        if (xfer) mcnt++;
        if (xfer || skip) begin
            if (pos == 7) begin
                void'(mq.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        @(posedge clk);
        #1;
        drive_din();
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 300 && (mq.size() > 0 || src.size() > 0); i++) step();
        check("drain_timeout", i, (i < 300) ? i : 0);
        step();
        check("drain_idle", {31'd0, dout_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_din_rd_en", {31'd0, din_rd_en}, 32'd0);
        check("rst_dout_last", {31'd0, dout_last}, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_count", tx_dw_count, 32'd0);
        mq.delete(); src.delete(); pos = 0; mcnt = 0; rd_pulses = 0; last_seen = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_din();
    endtask

    function automatic logic [255:0] rand_word(bit with_filler);
        logic [255:0] w;
        for (int k = 0; k < 8; k++) begin
            if (with_filler && $urandom_range(0, 3) == 0) w[k*32 +: 32] = FILLER;
            else w[k*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    initial begin
        logic [255:0] w;

        // Reset with no traffic.
        dout_ready = 1'b1;
        #2;
        do_reset();
        step();

        // Single known word, full-rate drain.
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = 32'h11111111 * (k + 1);
        src.push_back(w);
        drive_din();
        drain();
        check("single_count", tx_dw_count, 32'd8);
        check("single_last", last_seen, 1);

        // Back-to-back words with no output gap.
        do_reset();
        for (int n = 0; n < 4; n++) src.push_back(rand_word(0));
        drive_din();
        step(); step();
        check("b2b_first_pulses", rd_pulses, 2);
        drain();
        check("b2b_pulses", rd_pulses, 4);
        check("b2b_count", tx_dw_count, 32'd32);

        // Ready toggling with backpressure filling both slots.
        do_reset();
        for (int n = 0; n < 3; n++) src.push_back(rand_word(0));
        drive_din();
        for (int i = 0; i < 60; i++) begin
            dout_ready = i[0];
            step();
        end
        dout_ready = 1'b1;
        drain();
        check("toggle_count", tx_dw_count, 32'd24);

        // Reset in the middle of a word.
        do_reset();
        src.push_back(rand_word(0));
        drive_din();
        for (int i = 0; i < 20 && mcnt < 3; i++) step();
        check("mid_count", tx_dw_count, 32'd3);
        do_reset();
        src.push_back(rand_word(0));
        drive_din();
        drain();
        check("after_rst_count", tx_dw_count, 32'd8);

        // Filler DWs at positions 2 and 7.
        do_reset();
        w = rand_word(0);
        for (int k = 0; k < 8; k++) if (w[k*32 +: 32] == FILLER) w[k*32 +: 32] = 32'h0;
        w[2*32 +: 32] = FILLER;
        w[7*32 +: 32] = FILLER;
        src.push_back(w);
        drive_din();
        drain();
        check("filler_count", tx_dw_count, FDROP ? 32'd6 : 32'd8);
        check("filler_last", last_seen, FDROP ? 0 : 1);

        // All-filler word followed by a normal word.
        do_reset();
        src.push_back({8{FILLER}});
        src.push_back(rand_word(0));
        drive_din();
        drain();
        check("allfill_count", tx_dw_count, FDROP ? 32'd8 : 32'd16);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            while (src.size() < 2) src.push_back(rand_word(1));
            gate       = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            drive_din();
            step();
        end
        gate = 1'b1;
        dout_ready = 1'b1;
        drive_din();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
